ifns_encoder_seq_20: RTL and testbench

//  Sequential IFNS encoder: converts a 14-bit data word into a 20-wire Fibonacci-numeral codeword.

---
 rtl/ifns_encoder_seq_20_if.sv | 32 +++
 rtl/ifns_encoder_seq_20.sv | 175 +++++++++++++++++
 tb/tb_ifns_encoder_seq_20.sv | 379 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ifns_encoder_seq_20_if.sv
// ----------------------------------------------------------------------------
// ifns_encoder_seq_20_if
// Handshake bundle between a data producer, the sequential IFNS encoder and
// the coded-bus consumer.
//   datain      14   data word to encode
//   din_valid    1   datain is valid
//   din_ready    1   encoder can accept datain this cycle
//   codeout  [20:1]  registered Fibonacci-numeral codeword (coded bus)
//   dout_valid   1   codeout holds a new codeword
//   dout_ready   1   consumer takes the codeword
//   enc_err      1   sticky internal-fault flag
// Modports: slave = encoder side, master = producer/consumer side.
// ----------------------------------------------------------------------------
interface ifns_encoder_seq_20_if;
   logic [13:0] datain;
   logic        din_valid;
   logic        din_ready;
   logic [20:1] codeout;
   logic        dout_valid;
   logic        dout_ready;
   logic        enc_err;

   modport slave (
      input  datain, din_valid, dout_ready,
      output din_ready, codeout, dout_valid, enc_err
   );

   modport master (
      output datain, din_valid, dout_ready,
      input  din_ready, codeout, dout_valid, enc_err
   );
endinterface

// File: rtl/ifns_encoder_seq_20.sv
// ----------------------------------------------------------------------------
// ifns_encoder_seq_20
// Sequential IFNS encoder: converts a 14-bit data word into a 20-wire
// Fibonacci-numeral (Zeckendorf) codeword, one bit per cycle, MSB first, by
// greedy weight subtraction. Feeds the 20-wire IFNS decoder stage.
// Ports:
//   clock   in   single clock, rising edge
//   rst     in   synchronous active-high reset
//   bus     slave modport of ifns_encoder_seq_20_if (valid/ready in and out,
//           registered codeout, sticky enc_err)
// Latency: word accepted at edge E0 appears on codeout/dout_valid at E20.
// ----------------------------------------------------------------------------
module ifns_encoder_seq_20 #(
   parameter int DATA_W = 14,
   parameter int CODE_W = 20
) (
   input  logic                  clock,
   input  logic                  rst,
   ifns_encoder_seq_20_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      HOLD = 2'd2
   } state_t;

   // Fibonacci weight of codeword bit k (k = 1..20); 0 outside that range.
   function automatic logic [DATA_W:0] fib_weight(input logic [4:0] k);
      logic [DATA_W:0] w;
      case (k)
         5'd20:   w = 15'd10946;
         5'd19:   w = 15'd6765;
         5'd18:   w = 15'd4181;
         5'd17:   w = 15'd2584;
         5'd16:   w = 15'd1597;
         5'd15:   w = 15'd987;
         5'd14:   w = 15'd610;
         5'd13:   w = 15'd377;
         5'd12:   w = 15'd233;
         5'd11:   w = 15'd144;
         5'd10:   w = 15'd89;
         5'd9:    w = 15'd55;
         5'd8:    w = 15'd34;
         5'd7:    w = 15'd21;
         5'd6:    w = 15'd13;
         5'd5:    w = 15'd8;
         5'd4:    w = 15'd5;
         5'd3:    w = 15'd3;
         5'd2:    w = 15'd2;
         5'd1:    w = 15'd1;
         default: w = 15'd0;
      endcase
      return w;
   endfunction

   state_t            state_q, state_d;
   logic [DATA_W:0]   rem_q, rem_d;
   logic [4:0]        k_q, k_d;
   logic [CODE_W:1]   work_q, work_d;
   logic [CODE_W:1]   codeout_q, codeout_d;
   logic              dout_valid_q, dout_valid_d;
   logic              enc_err_q, enc_err_d;

   logic [DATA_W:0]   weight_s;
   logic              take_s;
   logic [DATA_W:0]   rem_sub_s;
   logic [CODE_W:1]   bit_mask_s;
   logic [CODE_W:1]   work_res_s;
   logic              din_ready_s;

   // Ready is combinational so a held word can be swapped for a new one on
   // the same edge the consumer takes it.
   assign din_ready_s = (state_q == IDLE) | ((state_q == HOLD) & bus.dout_ready);

   // One greedy step on bit k: take the weight if the remainder covers it.
   always_comb begin
      weight_s   = fib_weight(k_q);
      take_s     = (rem_q >= weight_s);
      bit_mask_s = {{(CODE_W-1){1'b0}}, 1'b1} << (k_q - 5'd1);
      if (take_s) begin
         rem_sub_s  = rem_q - weight_s;
         work_res_s = work_q | bit_mask_s;
      end else begin
         rem_sub_s  = rem_q;
         work_res_s = work_q;
      end
   end

   // Next-state and register-update logic of the IDLE/CONV/HOLD controller.
   always_comb begin
      state_d      = state_q;
      rem_d        = rem_q;
      k_d          = k_q;
      work_d       = work_q;
      codeout_d    = codeout_q;
      dout_valid_d = dout_valid_q;
      enc_err_d    = enc_err_q;
      case (state_q)
         IDLE: begin
            if (bus.din_valid) begin
               rem_d   = {1'b0, bus.datain};
               k_d     = 5'd20;
               work_d  = {CODE_W{1'b0}};
               state_d = CONV;
            end else begin
               state_d = IDLE;
            end
         end
         CONV: begin
            rem_d  = rem_sub_s;
            work_d = work_res_s;
            k_d    = k_q - 5'd1;
            if (k_q == 5'd1) begin
               // Only the finished word ever reaches the coded bus.
               codeout_d    = work_res_s;
               dout_valid_d = 1'b1;
               state_d      = HOLD;
               if (rem_sub_s != {(DATA_W+1){1'b0}}) begin
                  enc_err_d = 1'b1;
               end else begin
                  enc_err_d = enc_err_q;
               end
            end else begin
               state_d = CONV;
            end
         end
         HOLD: begin
            if (bus.dout_ready) begin
               dout_valid_d = 1'b0;
               if (bus.din_valid) begin
                  rem_d   = {1'b0, bus.datain};
                  k_d     = 5'd20;
                  work_d  = {CODE_W{1'b0}};
                  state_d = CONV;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               state_d = HOLD;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clock) begin
      if (rst) begin
         state_q      <= IDLE;
         rem_q        <= {(DATA_W+1){1'b0}};
         k_q          <= 5'd0;
         work_q       <= {CODE_W{1'b0}};
         codeout_q    <= {CODE_W{1'b0}};
         dout_valid_q <= 1'b0;
         enc_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         rem_q        <= rem_d;
         k_q          <= k_d;
         work_q       <= work_d;
         codeout_q    <= codeout_d;
         dout_valid_q <= dout_valid_d;
         enc_err_q    <= enc_err_d;
      end
   end

   assign bus.din_ready  = din_ready_s;
   assign bus.codeout    = codeout_q;
   assign bus.dout_valid = dout_valid_q;
   assign bus.enc_err    = enc_err_q;

endmodule

// File: tb/tb_ifns_encoder_seq_20.sv
// ----------------------------------------------------------------------------
// tb_ifns_encoder_seq_20
// Self-checking bench for ifns_encoder_seq_20. Expected codewords are pushed
// to a queue on each accepted word and popped when the encoder presents one.
// Inputs change and outputs are sampled just after the falling edge.
// ----------------------------------------------------------------------------
module tb_ifns_encoder_seq_20;

   logic clock = 1'b0;
   logic rst;

   ifns_encoder_seq_20_if bus();

   ifns_encoder_seq_20 dut (
      .clock (clock),
      .rst   (rst),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   int          checks   = 0;
   int          failures = 0;
   logic [19:0] exp_q[$];
   int          dat_q[$];
   int          fibw[1:20];

   // Zeckendorf representation built from the recurrence-generated weights.
   function automatic logic [19:0] zeck(input int v);
      int          r;
      logic [19:0] c;
      r = v;
      c = 20'h00000;
      for (int k = 20; k >= 1; k--) begin
         if (r >= fibw[k]) begin
            c[k-1] = 1'b1;
            r      = r - fibw[k];
         end
      end
      return c;
   endfunction

   // Value carried by a codeword, as the downstream decoder sees it.
   function automatic int decode(input logic [19:0] c);
      int s;
      s = 0;
      for (int k = 1; k <= 20; k++) begin
         if (c[k-1]) s = s + fibw[k];
      end
      return s;
   endfunction

   task automatic wait_valid(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 80; i++) begin
         if (bus.dout_valid === 1'b1) begin
            ok = 1'b1;
            break;
         end
         @(negedge clock); #1;
      end
      if (!ok) begin
         checks++; failures++;
         $display("FAIL dout_valid_timeout: got %b required 1", bus.dout_valid);
      end
   endtask

   task automatic send(input int v);
      bit ok;
      ok = 1'b0;
      bus.datain    = v[13:0];
      bus.din_valid = 1'b1;
      #1;
      for (int i = 0; i < 80; i++) begin
         if (bus.din_ready === 1'b1) begin
            ok = 1'b1;
            exp_q.push_back(zeck(v));
            dat_q.push_back(v);
            @(negedge clock); #1;
            bus.din_valid = 1'b0;
            bus.datain    = ~v[13:0];   // later changes must be ignored
            break;
         end
         @(negedge clock); #1;
      end
      if (!ok) begin
         checks++; failures++;
         $display("FAIL accept_timeout: din_ready got %b required 1", bus.din_ready);
         bus.din_valid = 1'b0;
      end
   endtask

   task automatic recv(input int hold);
      bit          ok;
      logic [19:0] e;
      logic [19:0] seen;
      int          v;
      bus.dout_ready = 1'b0;
      wait_valid(ok);
      if (ok) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL spurious_word: got codeout %h required no word", bus.codeout);
         end else begin
            e    = exp_q.pop_front();
            v    = dat_q.pop_front();
            seen = bus.codeout;
            if (seen !== e) begin
               failures++;
               $display("FAIL codeword: data %0d got %h required %h", v, seen, e);
            end
            checks++;
            if (decode(seen) != v) begin
               failures++;
               $display("FAIL decode: got %0d required %0d", decode(seen), v);
            end
            checks++;
            if ((seen & (seen >> 1)) !== 20'h00000) begin
               failures++;
               $display("FAIL adjacent_ones: got %h required no adjacent 1s", seen);
            end
            checks++;
            if (bus.enc_err !== 1'b0) begin
               failures++;
               $display("FAIL enc_err: got %b required 0", bus.enc_err);
            end
            repeat (hold) begin
               @(negedge clock); #1;
               checks++;
               if (bus.dout_valid !== 1'b1 || bus.codeout !== seen || bus.din_ready !== 1'b0) begin
                  failures++;
                  $display("FAIL hold_stable: got v=%b code=%h rdy=%b required 1 %h 0",
                           bus.dout_valid, bus.codeout, bus.din_ready, seen);
               end
            end
            bus.dout_ready = 1'b1;
            #1;
            checks++;
            if (bus.din_ready !== 1'b1) begin
               failures++;
               $display("FAIL hold_ready: din_ready got %b required 1", bus.din_ready);
            end
            @(negedge clock); #1;
            bus.dout_ready = 1'b0;
            checks++;
            if (bus.dout_valid !== 1'b0) begin
               failures++;
               $display("FAIL consume: dout_valid got %b required 0", bus.dout_valid);
            end
         end
      end
   endtask

   task automatic test_reset();
      rst            = 1'b1;
      bus.datain     = 14'd0;
      bus.din_valid  = 1'b0;
      bus.dout_ready = 1'b0;
      repeat (3) @(negedge clock);
      rst = 1'b0;
      #1;
      checks++;
      if (bus.codeout !== 20'h00000 || bus.dout_valid !== 1'b0 || bus.enc_err !== 1'b0 || bus.din_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_state: got code=%h v=%b err=%b rdy=%b required 00000 0 0 1",
                  bus.codeout, bus.dout_valid, bus.enc_err, bus.din_ready);
      end
   endtask

   task automatic test_values();
      send(0);     recv(0);
      send(1);     recv(1);
      send(100);   recv(0);
      send(16383); recv(2);
      checks++;
      if (bus.codeout !== 20'hA4882) begin
         failures++;
         $display("FAIL max_word: got %h required a4882", bus.codeout);
      end
   endtask

   task automatic test_latency();
      logic [19:0] prior;
      int          cnt;
      prior = bus.codeout;
      send(100);
      cnt = 0;
      while (bus.dout_valid !== 1'b1 && cnt < 40) begin
         checks++;
         if (bus.codeout !== prior) begin
            failures++;
            $display("FAIL bus_stable_conv: got %h required %h", bus.codeout, prior);
         end
         @(negedge clock); #1;
         cnt++;
      end
      checks++;
      if (cnt != 20) begin
         failures++;
         $display("FAIL latency: got %0d cycles required 20", cnt);
      end
      checks++;
      if (bus.codeout !== 20'h00214) begin
         failures++;
         $display("FAIL word_100: got %h required 00214", bus.codeout);
      end
      recv(0);
   endtask

   task automatic test_backpressure();
      bit          ok;
      logic [19:0] e;
      send(100);
      wait_valid(ok);
      e = exp_q[0];
      bus.datain    = 14'd5;
      bus.din_valid = 1'b1;
      #1;
      for (int i = 0; i < 50; i++) begin
         checks++;
         if (bus.dout_valid !== 1'b1 || bus.codeout !== e || bus.din_ready !== 1'b0) begin
            failures++;
            $display("FAIL backpressure: got v=%b code=%h rdy=%b required 1 %h 0",
                     bus.dout_valid, bus.codeout, bus.din_ready, e);
         end
         @(negedge clock); #1;
      end
      bus.dout_ready = 1'b1;
      #1;
      checks++;
      if (bus.din_ready !== 1'b1) begin
         failures++;
         $display("FAIL release_ready: din_ready got %b required 1", bus.din_ready);
      end
      void'(exp_q.pop_front());
      void'(dat_q.pop_front());
      exp_q.push_back(zeck(5));
      dat_q.push_back(5);
      @(negedge clock); #1;
      bus.din_valid  = 1'b0;
      bus.datain     = 14'h3FFF;
      checks++;
      if (bus.dout_valid !== 1'b0 || bus.din_ready !== 1'b0) begin
         failures++;
         $display("FAIL same_edge_accept: got v=%b rdy=%b required 0 0", bus.dout_valid, bus.din_ready);
      end
      bus.dout_ready = 1'b0;
      recv(0);
   endtask

   task automatic test_reset_mid_conv();
      logic [19:0] prior;
      prior = bus.codeout;
      send(16383);
      repeat (6) @(negedge clock);
      #1;
      checks++;
      if (bus.codeout !== prior || bus.dout_valid !== 1'b0) begin
         failures++;
         $display("FAIL pre_reset: got code=%h v=%b required %h 0", bus.codeout, bus.dout_valid, prior);
      end
      rst = 1'b1;
      @(negedge clock); #1;
      rst = 1'b0;
      exp_q.delete();
      dat_q.delete();
      checks++;
      if (bus.codeout !== 20'h00000 || bus.dout_valid !== 1'b0 || bus.enc_err !== 1'b0 || bus.din_ready !== 1'b1) begin
         failures++;
         $display("FAIL mid_conv_reset: got code=%h v=%b err=%b rdy=%b required 00000 0 0 1",
                  bus.codeout, bus.dout_valid, bus.enc_err, bus.din_ready);
      end
      for (int i = 0; i < 25; i++) begin
         @(negedge clock); #1;
         checks++;
         if (bus.dout_valid !== 1'b0) begin
            failures++;
            $display("FAIL discarded_word: dout_valid got %b required 0", bus.dout_valid);
         end
      end
      send(100);
      recv(1);
   endtask

   task automatic test_back_to_back();
      int vals[6] = '{2, 3, 4, 7, 12, 13000};
      int idx, got, last_cyc, cyc;
      bit adv;
      logic [19:0] e;
      int v;
      idx = 0; got = 0; last_cyc = -1; cyc = 0;
      bus.dout_ready = 1'b1;
      bus.datain     = vals[0][13:0];
      bus.din_valid  = 1'b1;
      #1;
      while (got < 6 && cyc < 400) begin
         adv = 1'b0;
         if (bus.dout_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL b2b_spurious: got %h required no word", bus.codeout);
            end else begin
               e = exp_q.pop_front();
               v = dat_q.pop_front();
               if (bus.codeout !== e) begin
                  failures++;
                  $display("FAIL b2b_codeword: data %0d got %h required %h", v, bus.codeout, e);
               end
            end
            if (last_cyc >= 0) begin
               checks++;
               if (cyc - last_cyc != 21) begin
                  failures++;
                  $display("FAIL b2b_period: got %0d required 21", cyc - last_cyc);
               end
            end
            last_cyc = cyc;
            got++;
         end
         if (bus.din_valid === 1'b1 && bus.din_ready === 1'b1) begin
            exp_q.push_back(zeck(vals[idx]));
            dat_q.push_back(vals[idx]);
            adv = 1'b1;
         end
         @(negedge clock); #1;
         cyc++;
         if (adv) begin
            idx++;
            if (idx < 6) bus.datain = vals[idx][13:0];
            else         bus.din_valid = 1'b0;
         end
      end
      checks++;
      if (got != 6) begin
         failures++;
         $display("FAIL b2b_count: got %0d words required 6", got);
      end
      bus.dout_ready = 1'b0;
      bus.din_valid  = 1'b0;
   endtask

   task automatic test_sweep();
      int v;
      for (int i = 0; i < 1200; i++) begin
         case (i)
            0:       v = 16383;
            1:       v = 10946;
            2:       v = 10945;
            3:       v = 2;
            default: v = $urandom_range(16383, 0);
         endcase
         send(v);
         recv($urandom_range(3, 0));
      end
      checks++;
      if (bus.enc_err !== 1'b0) begin
         failures++;
         $display("FAIL sweep_enc_err: got %b required 0", bus.enc_err);
      end
   endtask

   initial begin
      fibw[1] = 1;
      fibw[2] = 2;
      for (int k = 3; k <= 20; k++) fibw[k] = fibw[k-1] + fibw[k-2];
      test_reset();
      test_values();
      test_latency();
      test_backpressure();
      test_reset_mid_conv();
      test_back_to_back();
      test_sweep();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
